// File: rtl/instruction_memory_unit.sv
// Program store for the 8-bit accumulator core: byte-wide valid/ready loading while the core is held in reset, then zero-latency instruction fetch.
// The load port stalls through LoadReady once DEPTH words are stored. The instruction bus freezes at the HALT word once HALT is fetched.
module instruction_memory_unit #(
  parameter int         DEPTH       = 32,
  parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLB,
  input  logic       LoadValid,
  input  logic [7:0] LoadData,
  output logic       LoadReady,
  input  logic       LoadDone,
  input  logic [7:0] FromProcessor,
  output logic [7:0] ToProcessor,
  output logic       CoreReset,
  output logic       Halted,
  output logic [7:0] LoadCount,
  output logic [7:0] FetchCount
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [7:0]  mem [DEPTH];
  logic [8:0]  load_cnt;     // one bit wider than LoadCount so DEPTH=256 can be reached
  logic [7:0]  fetch_cnt;
  logic [7:0]  rd_word;
  logic        in_range;
  logic        accept;

  assign LoadCount  = load_cnt[7:0];
  assign FetchCount = fetch_cnt;

  // LoadCount gates every read, so stale memory from an earlier program is never visible.
  assign in_range = ({1'b0, FromProcessor} < load_cnt);
  assign rd_word  = in_range ? mem[FromProcessor[AW-1:0]] : 8'h00;
  assign accept   = LoadValid && LoadReady;

  always_ff @(posedge CLK) begin
    if (CLB) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    LoadReady   = 1'b0;
    CoreReset   = 1'b0;
    Halted      = 1'b0;
    ToProcessor = 8'h00;
    case (state)
      ST_LOAD: begin
        CoreReset = 1'b1;
        LoadReady = (load_cnt < DEPTH_W);
        if (LoadDone) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        ToProcessor = rd_word;
        if (rd_word[7:4] == HALT_OPCODE) begin
          next_state = ST_HALTED;
        end
      end
      ST_HALTED: begin
        Halted      = 1'b1;
        ToProcessor = {HALT_OPCODE, 4'b0000};
      end
      default: begin
        next_state = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLB) begin
      load_cnt  <= 9'd0;
      fetch_cnt <= 8'd0;
    end else begin
      if (accept) begin
        load_cnt <= load_cnt + 9'd1;
      end
      if (state == ST_RUN && fetch_cnt != 8'hFF) begin
        fetch_cnt <= fetch_cnt + 8'd1;
      end
    end
  end

  // Program storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (!CLB && accept) begin
      mem[load_cnt[AW-1:0]] <= LoadData;
    end
  end

endmodule

// File: tb/tb_instruction_memory_unit.sv
// Randomized bench for instruction_memory_unit: every cycle's outputs are compared against a behavioural program-store model.
module tb_instruction_memory_unit;

  logic       CLK = 1'b0;
  logic       CLB = 1'b1;
  logic       LoadValid = 1'b0;
  logic [7:0] LoadData = 8'h00;
  logic       LoadReady;
  logic       LoadDone = 1'b0;
  logic [7:0] FromProcessor = 8'h00;
  logic [7:0] ToProcessor;
  logic       CoreReset;
  logic       Halted;
  logic [7:0] LoadCount;
  logic [7:0] FetchCount;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain arrays and counters following the block's documented rules.
  logic [7:0] m_mem [256];
  int         m_cnt   = 0;
  int         m_fetch = 0;
  int         m_phase = 0;   // 0 = loading, 1 = running, 2 = halted

  logic [7:0] prog [19];

  instruction_memory_unit dut (
    .CLK(CLK), .CLB(CLB), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadReady(LoadReady), .LoadDone(LoadDone), .FromProcessor(FromProcessor),
    .ToProcessor(ToProcessor), .CoreReset(CoreReset), .Halted(Halted),
    .LoadCount(LoadCount), .FetchCount(FetchCount)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_fetch(input logic [7:0] pc);
    if (m_phase == 2) return 8'hF0;
    if (m_phase == 1) return (int'(pc) < m_cnt) ? m_mem[pc] : 8'h00;
    return 8'h00;
  endfunction

  // One clock: drive inputs, compare every output just before the edge, then advance the model.
  task automatic cycle(input logic clb, input logic v, input logic [7:0] d,
                       input logic done, input logic [7:0] pc);
    logic [7:0] e;
    @(negedge CLK);
    CLB = clb; LoadValid = v; LoadData = d; LoadDone = done; FromProcessor = pc;
    #1;
    e = model_fetch(pc);
    check_eq("to_processor", 32'(ToProcessor), 32'(e));
    check_eq("load_ready", 32'(LoadReady), 32'(m_phase == 0 && m_cnt < 32));
    check_eq("core_reset", 32'(CoreReset), 32'(m_phase == 0));
    check_eq("halted", 32'(Halted), 32'(m_phase == 2));
    check_eq("load_count", 32'(LoadCount), 32'(m_cnt));
    check_eq("fetch_count", 32'(FetchCount), 32'(m_fetch));
    if (clb) begin
      m_phase = 0; m_cnt = 0; m_fetch = 0;
    end else if (m_phase == 0) begin
      if (v && m_cnt < 32) begin
        m_mem[m_cnt] = d;
        m_cnt++;
      end
      if (done) m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_fetch < 255) m_fetch++;
      if (e[7:4] == 4'hF) m_phase = 2;
    end
    @(posedge CLK);
  endtask

  task automatic idle(input logic [7:0] pc);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, pc);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Loads n random bytes with random idle gaps; upper nibble never F so no accidental HALT.
  task automatic load_random(input int n);
    int k = 0;
    while (k < n) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(8'($urandom));
      end else begin
        cycle(1'b0, 1'b1, 8'($urandom) & 8'hEF, 1'b0, 8'($urandom));
        k++;
      end
    end
  endtask

  initial begin
    logic [7:0] pc;
    prog = '{8'hD5, 8'h50, 8'hD3, 8'h51, 8'hD0, 8'h10, 8'h21, 8'h52, 8'hB0, 8'h00,
             8'h00, 8'h00, 8'h20, 8'hAF, 8'hD0, 8'hD1, 8'h00, 8'h00, 8'hF0};

    // Power-up: DUT state is unknown until the first reset edge.
    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset_to_processor", 32'(ToProcessor), 32'h00);
    check_eq("reset_load_ready", 32'(LoadReady), 32'h1);
    check_eq("reset_core_reset", 32'(CoreReset), 32'h1);
    check_eq("reset_load_count", 32'(LoadCount), 32'h0);

    // Reference program with random gaps, then LoadDone.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      if ($urandom_range(0, 2) == 0) idle(8'($urandom));
      cycle(1'b0, 1'b1, prog[i], 1'b0, 8'($urandom));
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    #1;
    check_eq("prog_load_count", 32'(LoadCount), 32'd19);
    check_eq("prog_core_reset_fell", 32'(CoreReset), 32'h0);
    idle(8'd5);
    #1 check_eq("prog_pc5", 32'(ToProcessor), 32'h10);
    idle(8'd13);
    #1 check_eq("prog_pc13", 32'(ToProcessor), 32'hAF);
    idle(8'd19);
    #1 check_eq("prog_pc19", 32'(ToProcessor), 32'h00);
    idle(8'd200);
    #1 check_eq("prog_pc200", 32'(ToProcessor), 32'h00);
    for (int i = 0; i < 30; i++) begin
      pc = 8'($urandom);
      if (pc == 8'd18) pc = 8'd17;
      idle(pc);
    end
    #1 check_eq("prog_not_halted", 32'(Halted), 32'h0);
    idle(8'd18);
    #1 check_eq("halt_rise", 32'(Halted), 32'h1);
    check_eq("halt_fetch_count", 32'(FetchCount), 32'(m_fetch));
    idle(8'd3);
    #1 check_eq("halt_pc3", 32'(ToProcessor), 32'hF0);
    repeat (3) idle(8'($urandom));

    // Reset out of HALTED, then 40 back-to-back bytes into a 32-word store.
    do_reset();
    #1;
    check_eq("halt_reset_load_count", 32'(LoadCount), 32'h0);
    check_eq("halt_reset_halted", 32'(Halted), 32'h0);
    check_eq("halt_reset_to_processor", 32'(ToProcessor), 32'h00);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom) & 8'hEF, 1'b0, 8'($urandom));
    end
    #1;
    check_eq("full_load_count", 32'(LoadCount), 32'd32);
    check_eq("full_load_ready", 32'(LoadReady), 32'h0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 40; i++) idle(8'(i));

    // LoadDone coincident with a final byte.
    do_reset();
    load_random(3);
    cycle(1'b0, 1'b1, 8'h55, 1'b1, 8'h00);
    #1;
    check_eq("done_same_cycle_count", 32'(LoadCount), 32'd4);
    check_eq("done_same_cycle_run", 32'(CoreReset), 32'h0);
    idle(8'd3);
    #1 check_eq("done_same_cycle_pc3", 32'(ToProcessor), 32'h55);

    // Reset mid-load discards the partial program; stale words stay hidden.
    do_reset();
    load_random(10);
    do_reset();
    #1;
    check_eq("midload_reset_count", 32'(LoadCount), 32'h0);
    check_eq("midload_reset_core_reset", 32'(CoreReset), 32'h1);
    check_eq("midload_reset_load_ready", 32'(LoadReady), 32'h1);
    load_random(2);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    idle(8'd2);
    #1 check_eq("reload_pc2", 32'(ToProcessor), 32'h00);

    // Empty program runs as NOPs long enough to saturate FetchCount.
    do_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 270; i++) idle(8'($urandom));
    #1 check_eq("fetch_saturate", 32'(FetchCount), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_memory_unit.md
# instruction_memory_unit

Instruction-side responder for the 8-bit accumulator core. It receives the program counter the core drives on its instruction-memory port and returns the addressed 8-bit instruction in the same cycle. Before execution, a byte-wide valid/ready load port fills the program store while the core is held in reset. Once running, the block watches the fetched stream for the HALT opcode and freezes the instruction bus at HALT.

## Interface

- Parameters
  - DEPTH, default 32: number of 8-bit program words. Range 2..256.
  - HALT_OPCODE, default 4'b1111: upper nibble that marks HALT.
- Ports
  - CLK, in, 1: single clock; all state changes on its rising edge.
  - CLB, in, 1: reset, synchronous, active-high.
  - LoadValid, in, 1: the loader presents a program byte.
  - LoadData, in, 8: the program byte.
  - LoadReady, out, 1: the block accepts a byte this cycle.
  - LoadDone, in, 1: single-cycle pulse that ends loading.
  - FromProcessor, in, 8: program counter from the core.
  - ToProcessor, out, 8: instruction returned to the core.
  - CoreReset, out, 1: active-high hold for the core. High until execution starts.
  - Halted, out, 1: HALT has been fetched.
  - LoadCount, out, 8: number of words loaded.
  - FetchCount, out, 8: number of RUN cycles, saturating at 255.

## Operation

- The FSM has three states: LOAD, RUN and HALTED. Reset (CLB=1 at an edge) forces LOAD.
- Reset values:
  - LoadCount=0, FetchCount=0, Halted=0, CoreReset=1.
  - LoadReady=1, because the block is in LOAD.
  - ToProcessor=0x00.
  - Memory contents are not cleared. LoadCount gates every read instead.
- LOAD state
  - LoadReady = (LoadCount < DEPTH).
  - Each edge with LoadValid && LoadReady writes mem[LoadCount]=LoadData and increments LoadCount.
  - LoadValid while full (LoadCount==DEPTH) is ignored. The word is dropped and LoadCount does not change.
  - LoadDone at an edge moves the FSM to RUN. If LoadValid && LoadReady at that same edge, the byte is written first and is counted.
  - LoadDone with LoadCount==0 is legal. The program then reads entirely as NOP.
  - ToProcessor=0x00 and CoreReset=1 throughout.
- RUN state
  - CoreReset=0 and LoadReady=0. LoadValid and LoadDone are ignored.
  - ToProcessor is combinational: mem[FromProcessor] when FromProcessor < LoadCount, else 0x00 (NOP). This covers PCs at or beyond DEPTH.
  - FetchCount increments each RUN edge and saturates at 255.
  - At an edge where ToProcessor[7:4]==HALT_OPCODE, the FSM moves to HALTED. FetchCount still counts that edge.
- HALTED state
  - Halted=1 and CoreReset=0.
  - ToProcessor is forced to {HALT_OPCODE,4'b0000}, i.e. 0xF0 at the default parameter, regardless of PC.
  - FetchCount is frozen.
  - Only CLB exits this state, returning to LOAD with LoadCount=0. The program must then be reloaded.
- CLB has priority over every other input in every state. A reset mid-load discards the partial program by zeroing LoadCount.

## Timing

- Write latency: a byte accepted at edge N is readable in RUN from the cycle after edge N.
- Read latency: 0 cycles. ToProcessor follows FromProcessor combinationally within the cycle, in RUN only.
- LoadDone at edge N:
  - CoreReset falls and the state is RUN immediately after edge N.
  - The first fetch, of PC 0, is sampled by the core at edge N+1.
- HALT visible on ToProcessor during cycle K:
  - Halted rises after edge K.
  - ToProcessor stays equal to the HALT word before and after that edge, with no glitch to another value.
- Handshake: a transfer occurs only at an edge where both LoadValid and LoadReady are 1. LoadReady depends only on state and LoadCount, never on LoadValid.
- All outputs except ToProcessor are registered or decoded from registered state. ToProcessor additionally depends combinationally on FromProcessor.

## Test plan

- Load and run the 19-byte program 0xD5,0x50,0xD3,0x51,0xD0,0x10,0x21,0x52,0xB0,0x00,0x00,0x00,0x20,0xAF,0xD0,0xD1,0x00,0x00,0xF0, then pulse LoadDone. Required: LoadCount=19, CoreReset falls, PC=5 returns 0x10, PC=13 returns 0xAF.
- Out-of-range reads after the 19-byte load. Required: PC=19 and PC=200 both return 0x00, and Halted stays 0.
- Drive PC=18 in RUN. Required: ToProcessor=0xF0, Halted=1 after that edge, and a subsequent PC=3 still returns 0xF0. FetchCount stops at its value including the HALT edge.
- Offer 40 back-to-back bytes with LoadValid held high (DEPTH=32). Required: LoadReady drops after the 32nd accept, LoadCount=32, and bytes 33..40 are not stored.
- Assert LoadValid with 0x55 in the same cycle as LoadDone, after 3 loaded words. Required: LoadCount=4, the state is RUN, and PC=3 returns 0x55.
- Assert CLB after 10 words loaded, then again while HALTED. Required: each time LoadCount=0, CoreReset=1, Halted=0, LoadReady=1 and ToProcessor=0x00. Reloading 2 words then reads PC=2 as 0x00.
